// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit per clock on ser_o.
// Optional even-parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             frame_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef PISO_TX_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_SHIFT  = 2'd1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ser_q,   ser_d;
  logic               frame_q, frame_d;
  logic               done_q,  done_d;

  // Next-state and next-output logic. The shift register rotates rather than
  // shifts, so it still holds the whole word at frame end (parity is unchanged).
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ser_d   = IDLE_LEVEL;
        frame_d = 1'b0;
        if (valid_i) begin
          shreg_d = data_i;
          cnt_d   = '0;
          state_d = ST_SHIFT;
          ser_d   = (MSB_FIRST != 0) ? data_i[WIDTH-1] : data_i[0];
          frame_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
          ser_d   = ^shreg_q;
`else
          state_d = ST_IDLE;
          ser_d   = IDLE_LEVEL;
          frame_d = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (MSB_FIRST != 0) begin
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            ser_d   = shreg_q[WIDTH-2];
          end else begin
            shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
            ser_d   = shreg_q[1];
          end
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
        ser_d   = IDLE_LEVEL;
        frame_d = 1'b0;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        ser_d   = IDLE_LEVEL;
        frame_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= IDLE_LEVEL;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = ~ready_o;
  assign ser_o   = ser_q;
  assign frame_o = frame_q;
  assign done_o  = done_q;

endmodule
